ascon_perm_core: RTL and testbench



---
 rtl/ascon_perm_core.sv | 127 ++++++++++++
 tb/tb_ascon_perm_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_core.sv
// Iterative Ascon permutation p^a (a = 1..12) on a 320-bit state.
// Performs up to UNROLL rounds per clock, with a start/valid handshake.
`timescale 1ns/1ps
module ascon_perm_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [319:0] state_o
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6)) begin : g_bad_unroll
      $error("ascon_perm_core: UNROLL must be 1, 2, 3, 4 or 6");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [319:0]   state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     a_clamp;
  logic [4:0]     idx_step;
  logic [UNROLL:0][319:0] chain;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2[7:0] = x2[7:0] ^ {4'hF - i, i};
    // Bit-sliced S-box: every bit position is one 5-bit column.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign chain[0] = state_q;

  // Stages past round 11 pass their input through, so a partial last cycle is exact.
  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
      logic [4:0] ri;
      assign ri = {1'b0, idx_q} + 5'(gi);
      assign chain[gi+1] = (ri < 5'd12) ? ascon_round(chain[gi], ri[3:0]) : chain[gi];
    end
  endgenerate

  assign a_clamp  = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
  assign idx_step = {1'b0, idx_q} + 5'(UNROLL);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = state_i;
          idx_d   = 4'd12 - a_clamp;
          fsm_d   = (a_clamp == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        state_d = chain[UNROLL];
        if (idx_step >= 5'd12) begin
          idx_d = 4'd12;
          fsm_d = DONE;
        end else begin
          idx_d = idx_step[3:0];
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign ready_o = (fsm_q != RUN);
  assign valid_o = (fsm_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: all five UNROLL builds share one stimulus stream
// and are checked every cycle against a table-driven software Ascon model.
`timescale 1ns/1ps
module tb_ascon_perm_core;
  localparam int NU = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [3:0]   rounds_i = 4'd0;
  logic [319:0] state_i = '0;
  logic         ready_o [NU];
  logic         valid_o [NU];
  logic [319:0] state_o [NU];

  int checks = 0;
  int errors = 0;
  int lat [NU];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  localparam logic [319:0] LIT_A1_ZERO = {64'h000964B00000004B, 64'h0000000096000213,
                                          64'h53FFFFFFFFFFFF90, 64'h12E580000000004B,
                                          64'h0000000000000000};

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NU; g++) begin : g_dut
      localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 6;
      ascon_perm_core #(.UNROLL(U)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .ready_o  (ready_o[g]),
        .valid_o  (valid_o[g]),
        .state_o  (state_o[g])
      );
    end
  endgenerate

  function automatic int unr(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference p^a: rounds 12-a .. 11, S-box by table lookup per column.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int a);
    logic [63:0] x [5];
    logic [4:0]  col, y;
    for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
    for (int r = 12 - a; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        y = SBOX[col];
        x[0][b] = y[4]; x[1][b] = y[3]; x[2][b] = y[2]; x[3][b] = y[1]; x[4][b] = y[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input string nm, input int g, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d got %h want %h", nm, unr(g), act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s u%0d got %0d want %0d", nm, unr(g), act, exp);
    end
  endtask

  // Expected behaviour per instance: remaining compute cycles, valid, and result.
  int           cnt_m   [NU] = '{default: 0};
  bit           valid_m [NU] = '{default: 1'b0};
  bit           known_m [NU] = '{default: 1'b1};
  logic [319:0] res_m   [NU] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    int a;
    if (rst) begin
      for (int g = 0; g < NU; g++) begin
        cnt_m[g] = 0; valid_m[g] = 1'b0; known_m[g] = 1'b1; res_m[g] = '0;
      end
    end else begin
      for (int g = 0; g < NU; g++) begin
        if (cnt_m[g] == 0) begin
          if (start_i) begin
            a = (int'(rounds_i) > 12) ? 12 : int'(rounds_i);
            res_m[g]   = ref_perm(state_i, a);
            cnt_m[g]   = (a + unr(g) - 1) / unr(g);
            valid_m[g] = (cnt_m[g] == 0);
            known_m[g] = valid_m[g];
          end
        end else begin
          cnt_m[g]--;
          if (cnt_m[g] == 0) begin
            valid_m[g] = 1'b1;
            known_m[g] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NU; g++) begin
        chk("ready", g, 320'(ready_o[g]), 320'(cnt_m[g] == 0));
        chk("valid", g, 320'(valid_o[g]), 320'(valid_m[g]));
        if (known_m[g]) chk("state", g, state_o[g], res_m[g]);
      end
    end
  end

  task automatic wait_all_ready();
    bit ok;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ok = 1'b1;
      for (int g = 0; g < NU; g++) if (!ready_o[g]) ok = 1'b0;
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout got 0 want 1");
  endtask

  task automatic run_one(input logic [319:0] s, input logic [3:0] r,
                         input bit pulse, input logic [319:0] s2);
    bit all;
    wait_all_ready();
    state_i = s; rounds_i = r; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int g = 0; g < NU; g++) lat[g] = -1;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      for (int g = 0; g < NU; g++) if (lat[g] < 0 && valid_o[g]) lat[g] = t;
      if (pulse && t == 1) begin start_i = 1'b1; state_i = s2; end
      if (pulse && t == 2) start_i = 1'b0;
      all = 1'b1;
      for (int g = 0; g < NU; g++) if (lat[g] < 0) all = 1'b0;
      if (all && (!pulse || t >= 2)) break;
    end
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int w = 0; w < 10; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int lat12 [NU] = '{12, 6, 4, 3, 2};
    int lat8  [NU] = '{8, 4, 3, 2, 2};
    int lat6  [NU] = '{6, 3, 2, 2, 1};
    logic [319:0] s, s2;
    int a;

    // Pin the reference model with hand-computed values.
    chk("model_p1_zero", 0, ref_perm('0, 1), LIT_A1_ZERO);
    s = rand320();
    chk("model_p0", 0, ref_perm(s, 0), s);

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NU; g++) begin
      chk("rst_ready", g, 320'(ready_o[g]), 320'(1));
      chk("rst_valid", g, 320'(valid_o[g]), 320'(0));
      chk("rst_state", g, state_o[g], '0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_one('0, 4'd1, 1'b0, '0);
    for (int g = 0; g < NU; g++) begin
      chk_int("lat_a1", g, lat[g], 1);
      chk("p1_zero", g, state_o[g], LIT_A1_ZERO);
    end

    run_one('0, 4'd12, 1'b0, '0);
    for (int g = 0; g < NU; g++) chk_int("lat_a12", g, lat[g], lat12[g]);

    s = rand320();
    run_one(s, 4'd8, 1'b0, '0);
    for (int g = 0; g < NU; g++) chk_int("lat_a8", g, lat[g], lat8[g]);
    s = rand320();
    run_one(s, 4'd6, 1'b0, '0);
    for (int g = 0; g < NU; g++) chk_int("lat_a6", g, lat[g], lat6[g]);

    s = rand320();
    run_one(s, 4'd0, 1'b0, '0);
    for (int g = 0; g < NU; g++) begin
      chk_int("lat_a0", g, lat[g], 0);
      chk("a0_passthru", g, state_o[g], s);
    end

    s = rand320();
    run_one(s, 4'd15, 1'b0, '0);
    for (int g = 0; g < NU; g++) begin
      chk_int("lat_a15", g, lat[g], lat12[g]);
      chk("a15_as_a12", g, state_o[g], ref_perm(s, 12));
    end

    s = rand320();
    s2 = rand320();
    run_one(s, 4'd12, 1'b1, s2);
    for (int g = 0; g < NU; g++) chk("ignore_midrun", g, state_o[g], ref_perm(s, 12));

    // Start held high: back-to-back permutations, checked cycle by cycle.
    wait_all_ready();
    state_i = rand320(); rounds_i = 4'd5; start_i = 1'b1;
    repeat (40) @(negedge clk);
    start_i = 1'b0;

    // Asynchronous reset in the middle of a run.
    wait_all_ready();
    state_i = rand320(); rounds_i = 4'd12; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int g = 0; g < NU; g++) begin
      chk("midrst_ready", g, 320'(ready_o[g]), 320'(1));
      chk("midrst_valid", g, 320'(valid_o[g]), 320'(0));
      chk("midrst_state", g, state_o[g], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    s = rand320();
    run_one(s, 4'd12, 1'b0, '0);
    for (int g = 0; g < NU; g++) begin
      chk_int("lat_after_rst", g, lat[g], lat12[g]);
      chk("after_rst", g, state_o[g], ref_perm(s, 12));
    end

    for (int n = 0; n < 1000 && errors < 50; n++) begin
      a = $urandom_range(1, 12);
      run_one(rand320(), 4'(a), 1'b0, '0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
